data_mem_responder: RTL and testbench

Memory-side responder for the core's data-memory port: accepts one load or store request at a time from the memory stage over a valid/ready handshake, inserts a programmable number of wait states, and returns exactly one response per accepted request. Holds a word-addressed data array and flags misaligned or out-of-range accesses. Lets the pipeline be exercised against a non-zero-latency memory, replacing the single-cycle MemoryUnit array.

---
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the core's data-memory port. Accepts one load or
// store at a time, holds it for a programmable number of wait states, then
// returns exactly one single-cycle response. Backed by a word-addressed array
// that is cleared by reset.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and never while
// reset is asserted. The response side has no backpressure: resp_valid is a
// one-cycle strobe and resp_rdata/resp_err are only meaningful while it is
// high.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address (must be word aligned and in range)
//   req_wdata             store data
//   resp_valid            one-cycle response strobe
//   resp_rdata            load data; 0 for stores and for errored requests
//   resp_err              misaligned or out-of-range access
//   busy                  a request is in flight (state is not IDLE)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             addr_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem_rd;
    logic             commit;
    logic             mem_we;

    // Range check done in 33 bits so 4*DEPTH_WORDS never overflows.
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      ({1'b0, addr_q} >= (33'(DEPTH_WORDS) << 2));
    assign idx      = addr_q[IDX_W+1:2];
    assign mem_rd   = mem_q[idx];
    assign mem_we   = commit && we_q && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // The counter holds WAIT_CYCLES rather than WAIT_CYCLES-1:
                    // the cycle right after accept is spent checking the
                    // latched address, so commit lands WAIT_CYCLES+1 edges
                    // after accept (one edge when WAIT_CYCLES is 0).
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            err_d   = addr_err;
            // Stores and errored requests report zero data.
            rdata_d = (!we_q && !addr_err) ? mem_rd : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Only one request is ever in flight and a store returns no data, so the
    // read and write on the commit edge never target a word of interest to
    // each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // req_ready is gated by reset so nothing is accepted while it is held.
    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Three responder instances with different wait-state settings:
//   0: WAIT_CYCLES=2 (table-driven vectors, reset/idle, input stability)
//   1: WAIT_CYCLES=0 (back-to-back stores with req_valid held high)
//   2: WAIT_CYCLES=4 (reset while a store is in flight)
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk;
    logic        rst   [3];
    logic        vld   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        rdy   [3];
    logic        rv    [3];
    logic [31:0] rdata [3];
    logic        err   [3];
    logic        busy  [3];

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(we[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .resp_valid(rv[0]), .resp_rdata(rdata[0]), .resp_err(err[0]),
        .busy(busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(we[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .resp_valid(rv[1]), .resp_rdata(rdata[1]), .resp_err(err[1]),
        .busy(busy[1])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) dut_w4 (
        .clk(clk), .reset(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_we(we[2]), .req_addr(addr[2]), .req_wdata(wdata[2]),
        .resp_valid(rv[2]), .resp_rdata(rdata[2]), .resp_err(err[2]),
        .busy(busy[2])
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]   = 1'b1;
            vld[k]   = 1'b0;
            we[k]    = 1'b0;
            addr[k]  = '0;
            wdata[k] = '0;
        end
    end

    // ---------------- response pulse monitors ----------------
    int   pulses1 = 0;
    int   wide1   = 0;
    int   pulses2 = 0;
    logic rv1_prev = 1'b0;

    always @(negedge clk) begin
        if (rv[1] === 1'b1) pulses1++;
        if (rv[1] === 1'b1 && rv1_prev === 1'b1) wide1++;
        rv1_prev = rv[1];
        if (rv[2] === 1'b1) pulses2++;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full request on instance k. Returns the response data/error and the
    // number of edges from the accept edge to the edge that raised resp_valid.
    // With scramble set, req_valid stays high and the other request inputs
    // toggle every cycle while the request is in flight.
    task automatic do_req(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble,
                          output logic [31:0] rd, output logic e, output int lat);
        int guard;
        @(negedge clk);
        vld[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        guard = 0;
        while (rdy[k] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(rdy[k]), 32'd1);
        @(posedge clk);
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        @(negedge clk);
        if (!scramble) vld[k] = 1'b0;
        while (rv[k] !== 1'b1 && lat < 40) begin
            chk("busy_in_flight", 32'(busy[k]), 32'd1);
            chk("not_ready_in_flight", 32'(rdy[k]), 32'd0);
            if (scramble) begin
                we[k]    = ~we[k];
                addr[k]  = (addr[k] == 32'h40) ? 32'h4C : 32'h40;
                wdata[k] = $urandom;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("resp_seen", 32'(rv[k]), 32'd1);
        rd = rdata[k];
        e  = err[k];
        chk("busy_in_resp", 32'(busy[k]), 32'd1);
        vld[k] = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", 32'(rv[k]), 32'd0);
        chk("idle_busy", 32'(busy[k]), 32'd0);
        chk("idle_ready", 32'(rdy[k]), 32'd1);
    endtask

    // ---------------- test vectors ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_data [4];
    int          acc [4];

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0044, 32'h0,         32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0042, 32'h1234_5678, 32'h0,         1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'h0000_1000, 32'h0000_0055, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0,         1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_1FFC, 32'h0,         32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
        vecs[13] = '{1'b1, 32'h0000_0041, 32'h7777_7777, 32'h0,         1'b1};
        vecs[14] = '{1'b0, 32'h0000_0043, 32'h0,         32'h0,         1'b1};

        b2b_addr[0] = 32'h0; b2b_data[0] = 32'hA0A0_0001;
        b2b_addr[1] = 32'h4; b2b_data[1] = 32'hB0B0_0002;
        b2b_addr[2] = 32'h8; b2b_data[2] = 32'hC0C0_0003;
        b2b_addr[3] = 32'hC; b2b_data[3] = 32'hD0D0_0004;

        // ---- reset / idle ----
        repeat (2) @(negedge clk);
        chk("ready_while_reset", 32'(rdy[0]), 32'd0);
        chk("busy_while_reset", 32'(busy[0]), 32'd0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #1;
        chk("ready_after_reset", 32'(rdy[0]), 32'd1);
        chk("busy_after_reset", 32'(busy[0]), 32'd0);
        chk("rv_after_reset", 32'(rv[0]), 32'd0);
        chk("rdata_after_reset", rdata[0], 32'h0);
        chk("err_after_reset", 32'(err[0]), 32'd0);

        // mid-cycle reset pulse on the idle instance
        @(posedge clk);
        #3 rst[0] = 1'b1;
        @(negedge clk);
        chk("ready_mid_reset", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        chk("ready_post_pulse", 32'(rdy[0]), 32'd1);

        // ---- table-driven vectors, WAIT_CYCLES=2 ----
        for (int i = 0; i < 15; i++) begin
            do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rd, e, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // ---- input stability while busy ----
        do_req(0, 1'b1, 32'h48, 32'h1111_2222, 1'b1, rd, e, lat);
        chk("stab_store_err", 32'(e), 32'd0);
        chk("stab_store_latency", 32'(lat), 32'd3);
        do_req(0, 1'b0, 32'h48, 32'h0, 1'b0, rd, e, lat);
        chk("stab_readback", rd, 32'h1111_2222);
        do_req(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, e, lat);
        chk("stab_untouched_40", rd, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 32'h4C, 32'h0, 1'b0, rd, e, lat);
        chk("stab_untouched_4c", rd, 32'h0);

        // ---- back-to-back stores, WAIT_CYCLES=0, req_valid held high ----
        begin
            int t;
            int guard;
            t = 0;
            @(negedge clk);
            vld[1] = 1'b1;
            we[1]  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                addr[1]  = b2b_addr[i];
                wdata[1] = b2b_data[i];
                exp_q.push_back(b2b_data[i]);
                guard = 0;
                while (rdy[1] !== 1'b1 && guard < 20) begin
                    @(posedge clk);
                    t++;
                    @(negedge clk);
                    guard++;
                end
                chk("b2b_accept_ready", 32'(rdy[1]), 32'd1);
                @(posedge clk);
                t++;
                acc[i] = t;
                @(negedge clk);
            end
            vld[1] = 1'b0;
            repeat (4) @(negedge clk);
            for (int i = 1; i < 4; i++) begin
                chk($sformatf("b2b_spacing%0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
            end
            chk("b2b_pulse_count", 32'(pulses1), 32'd4);
            chk("b2b_pulse_width", 32'(wide1), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_v;
            do_req(1, 1'b0, b2b_addr[i], 32'h0, 1'b0, rd, e, lat);
            exp_v = exp_q.pop_front();
            chk($sformatf("b2b_readback%0d", i), rd, exp_v);
            chk($sformatf("b2b_err%0d", i), 32'(e), 32'd0);
            chk($sformatf("b2b_latency%0d", i), 32'(lat), 32'd1);
        end

        // ---- reset mid-flight, WAIT_CYCLES=4 ----
        @(negedge clk);
        vld[2]   = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 32'h80;
        wdata[2] = 32'hAAAA_5555;
        chk("mf_ready_before", 32'(rdy[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        vld[2] = 1'b0;
        chk("mf_busy_accepted", 32'(busy[2]), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2 rst[2] = 1'b1;
        @(negedge clk);
        chk("mf_busy_in_reset", 32'(busy[2]), 32'd0);
        chk("mf_ready_in_reset", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        chk("mf_ready_in_reset2", 32'(rdy[2]), 32'd0);
        rst[2] = 1'b0;
        #1;
        chk("mf_ready_after", 32'(rdy[2]), 32'd1);
        repeat (8) @(negedge clk);
        chk("mf_no_resp", 32'(pulses2), 32'd0);
        do_req(2, 1'b0, 32'h80, 32'h0, 1'b0, rd, e, lat);
        chk("mf_load_rdata", rd, 32'h0);
        chk("mf_load_err", 32'(e), 32'd0);
        chk("mf_load_latency", 32'(lat), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
